v_lsu_sequencer: RTL and testbench



---
 rtl/v_lsu_sequencer.sv | 151 +++++++++++++++
 tb/tb_v_lsu_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/v_lsu_sequencer.sv
// Vector LSU sequencer: splits one load/store request into 4-element beats across four memory banks.
// Latency: first beat 1 cycle after handshake; holds on beat_ready=0; done pulses the cycle after the last beat.
module v_lsu_sequencer #(
   parameter int VLEN   = 128,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic              req_strided,
   input  logic [2:0]        req_vsew,
   input  logic [2:0]        req_lmul,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [4:0]        req_stride,
   output logic              beat_valid,
   input  logic              beat_ready,
   output logic [3:0]        beat_idx,
   output logic [ADDR_W-1:0] bank_addr0,
   output logic [ADDR_W-1:0] bank_addr1,
   output logic [ADDR_W-1:0] bank_addr2,
   output logic [ADDR_W-1:0] bank_addr3,
   output logic [3:0]        bank_we,
   output logic              busy,
   output logic              done,
   input  logic              flush
);

   // Beats per register: each beat carries four elements.
   localparam logic [4:0] BPR8  = 5'(VLEN / 32);
   localparam logic [4:0] BPR16 = 5'(VLEN / 64);
   localparam logic [4:0] BPR32 = 5'(VLEN / 128);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              store_q, strided_q;
   logic [2:0]        vsew_q, lmul_q;
   logic [ADDR_W-1:0] base_q;
   logic [4:0]        stride_q;
   logic [4:0]        bpr, nreg;
   logic [9:0]        total;
   logic              last_beat;
   logic              accept;
   logic [ADDR_W-1:0] addr [4];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         store_q   <= 1'b0;
         strided_q <= 1'b0;
         vsew_q    <= '0;
         lmul_q    <= '0;
         base_q    <= '0;
         stride_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            store_q   <= req_store;
            strided_q <= req_strided;
            vsew_q    <= req_vsew;
            lmul_q    <= req_lmul;
            base_q    <= req_base;
            stride_q  <= req_stride;
         end
      end
   end

   always_comb begin
      bpr = BPR32;
      case (vsew_q)
         3'b000:  bpr = BPR8;
         3'b001:  bpr = BPR16;
         default: bpr = BPR32;
      endcase
      nreg = 5'd1;
      case (lmul_q)
         3'b001:  nreg = 5'd2;
         3'b010:  nreg = 5'd4;
         default: nreg = 5'd1;
      endcase
      total     = 10'(bpr) * 10'(nreg);
      last_beat = ({6'd0, cnt} == total - 10'd1);
   end

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      beat_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            beat_valid = 1'b1;
            busy       = 1'b1;
            if (flush) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (beat_ready) begin
               if (last_beat) begin
                  state_nxt = DONE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
         end
         DONE: begin
            // A flush landing on the done cycle swallows the pulse.
            done      = !flush && !rst;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Element index of bank b at beat n is 4n+b; arithmetic wraps at ADDR_W bits.
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         logic [ADDR_W-1:0] elem;
         elem = ADDR_W'({cnt, 2'b00}) + ADDR_W'(b);
         if (!beat_valid)
            addr[b] = '0;
         else if (strided_q)
            addr[b] = base_q + ADDR_W'(stride_q) * elem;
         else
            addr[b] = base_q + elem;
      end
   end

   assign beat_idx   = beat_valid ? cnt : 4'd0;
   assign bank_addr0 = addr[0];
   assign bank_addr1 = addr[1];
   assign bank_addr2 = addr[2];
   assign bank_addr3 = addr[3];
   assign bank_we    = {4{store_q & beat_valid}};

endmodule

// File: tb/tb_v_lsu_sequencer.sv
// Directed bench for v_lsu_sequencer with an expected-beat scoreboard queue.
module tb_v_lsu_sequencer;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rst, req_valid, req_ready, req_store, req_strided;
   logic [2:0]    req_vsew, req_lmul;
   logic [AW-1:0] req_base;
   logic [4:0]    req_stride;
   logic          beat_valid, beat_ready;
   logic [3:0]    beat_idx;
   logic [AW-1:0] bank_addr0, bank_addr1, bank_addr2, bank_addr3;
   logic [3:0]    bank_we;
   logic          busy, done, flush;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0]    idx;
      logic [AW-1:0] a0, a1, a2, a3;
      logic [3:0]    we;
   } beat_t;

   beat_t exp_q[$];

   v_lsu_sequencer #(.VLEN(128), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_strided(req_strided), .req_vsew(req_vsew),
      .req_lmul(req_lmul), .req_base(req_base), .req_stride(req_stride),
      .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_idx(beat_idx),
      .bank_addr0(bank_addr0), .bank_addr1(bank_addr1), .bank_addr2(bank_addr2),
      .bank_addr3(bank_addr3), .bank_we(bank_we), .busy(busy), .done(done),
      .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] maddr(input logic sd, input logic [AW-1:0] base,
                                          input logic [4:0] stride, input int e);
      int v;
      v = sd ? int'(base) + int'(stride) * e : int'(base) + e;
      return v[AW-1:0];
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_valid"}, beat_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_we"}, bank_we, 0);
      chk({tag, "_idx"}, beat_idx, 0);
      chk({tag, "_a0"}, bank_addr0, 0);
      chk({tag, "_a3"}, bank_addr3, 0);
   endtask

   // nb: expected beat count; abort_at >= 0 aborts at that beat via flush (abort_rst=0) or rst (1).
   task automatic run_req(input string nm, input logic st, input logic sd,
                          input logic [2:0] vsew, input logic [2:0] lmul,
                          input logic [AW-1:0] base, input logic [4:0] stride,
                          input int nb, input int stall_at, input int stall_len,
                          input int abort_at, input bit abort_rst);
      beat_t e;
      int cyc, stalled;
      for (int n = 0; n < nb; n++) begin
         e.idx = 4'(n);
         e.a0  = maddr(sd, base, stride, 4 * n + 0);
         e.a1  = maddr(sd, base, stride, 4 * n + 1);
         e.a2  = maddr(sd, base, stride, 4 * n + 2);
         e.a3  = maddr(sd, base, stride, 4 * n + 3);
         e.we  = st ? 4'hF : 4'h0;
         exp_q.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_strided = sd;
      req_vsew = vsew; req_lmul = lmul; req_base = base; req_stride = stride;
      #1 chk({nm, "_req_ready"}, req_ready, 1);
      @(negedge clk);
      // Scramble live inputs so only captured fields can produce correct beats.
      req_valid = 1'b0; req_store = ~st; req_strided = ~sd;
      req_vsew = 3'b000; req_lmul = 3'b010; req_base = ~base; req_stride = ~stride;
      cyc = 0; stalled = 0;
      while (exp_q.size() > 0) begin
         if (cyc >= 200) begin
            chk({nm, "_timeout"}, 1, 0);
            exp_q.delete();
            break;
         end
         e = exp_q[0];
         beat_ready = !(int'(e.idx) == stall_at && stalled < stall_len);
         if (!beat_ready) stalled++;
         #1;
         chk({nm, "_valid"}, beat_valid, 1);
         chk({nm, "_busy"}, busy, 1);
         chk({nm, "_rdy_low"}, req_ready, 0);
         chk({nm, "_idx"}, beat_idx, e.idx);
         chk({nm, "_a0"}, bank_addr0, e.a0);
         chk({nm, "_a1"}, bank_addr1, e.a1);
         chk({nm, "_a2"}, bank_addr2, e.a2);
         chk({nm, "_a3"}, bank_addr3, e.a3);
         chk({nm, "_we"}, bank_we, e.we);
         if (int'(e.idx) == abort_at) begin
            if (abort_rst) rst = 1'b1; else flush = 1'b1;
            @(negedge clk);
            rst = 1'b0; flush = 1'b0; beat_ready = 1'b1;
            #1 chk_quiet({nm, "_abort"});
            chk({nm, "_abort_rdy"}, req_ready, 1);
            @(negedge clk);
            #1 chk({nm, "_abort_nodone"}, done, 0);
            exp_q.delete();
            return;
         end
         if (beat_ready) void'(exp_q.pop_front());
         cyc++;
         @(negedge clk);
      end
      beat_ready = 1'b1;
      #1 chk({nm, "_done"}, done, 1);
      chk({nm, "_done_busy"}, busy, 0);
      chk({nm, "_done_valid"}, beat_valid, 0);
      chk({nm, "_done_we"}, bank_we, 0);
      chk({nm, "_latency"}, cyc, nb + stall_len);
      @(negedge clk);
      #1 chk({nm, "_done_off"}, done, 0);
      chk({nm, "_rdy_again"}, req_ready, 1);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = 1'b1; beat_ready = 1'b1;
      req_store = 1'b0; req_strided = 1'b0; req_vsew = '0; req_lmul = '0;
      req_base = '0; req_stride = '0;
      repeat (2) @(negedge clk);
      #1 chk_quiet("reset");
      chk("reset_rdy", req_ready, 0);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("post_reset_rdy", req_ready, 1);
      chk_quiet("idle");

      run_req("t1_us_st32",  1, 0, 3'b010, 3'b000, 14'h010, 5'd0, 1, -1, 0, -1, 0);
      run_req("t2_us_ld8x2", 0, 0, 3'b000, 3'b001, 14'h000, 5'd0, 8, -1, 0, -1, 0);
      run_req("t3_sd_st16",  1, 1, 3'b001, 3'b000, 14'd5,   5'd3, 2, -1, 0, -1, 0);
      run_req("t4_stall",    0, 0, 3'b000, 3'b001, 14'h000, 5'd0, 8,  4, 3, -1, 0);
      run_req("t5_wrap",     1, 0, 3'b010, 3'b000, 14'h3FFE, 5'd0, 1, -1, 0, -1, 0);
      run_req("t6_flush",    1, 0, 3'b000, 3'b000, 14'h100, 5'd0, 4, -1, 0, 2, 0);
      run_req("t6_after",    0, 1, 3'b001, 3'b010, 14'h020, 5'd0, 8, -1, 0, -1, 0);
      run_req("t6_rst",      0, 0, 3'b000, 3'b000, 14'h040, 5'd7, 4, -1, 0, 2, 1);
      run_req("t7_sd_wrap",  1, 1, 3'b000, 3'b010, 14'h3F00, 5'd31, 16, 9, 2, -1, 0);
      run_req("t8_odd_codes", 0, 1, 3'b111, 3'b111, 14'h200, 5'd2, 1, -1, 0, -1, 0);

      // Flush while idle must be ignored.
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1 chk("idle_flush_rdy", req_ready, 1);
      chk_quiet("idle_flush");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
